reorder_buffer: RTL

//  In-order commit queue for the out-of-order core. Allocates a ROB id per issued instruction,

---
 rtl/reorder_buffer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer
// Purpose  : In-order commit queue: ROB id allocation, CDB capture, operand
//            lookup, in-order retire and mispredict flush.
// Revision : 1.0  initial release
// ============================================================================
module reorder_buffer #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 readyIn,
  input  logic                 issueValid,
  input  logic                 issueRdFlag,
  input  logic [4:0]           issueRd,
  input  logic                 issueBranch,
  output logic [ROB_WIDTH-1:0] issueId,
  output logic                 full,
  input  logic                 cdbValid,
  input  logic [ROB_WIDTH-1:0] cdbRobId,
  input  logic [31:0]          cdbValue,
  input  logic                 cdbMispredict,
  input  logic [31:0]          cdbTarget,
  input  logic [ROB_WIDTH-1:0] query1Id,
  output logic                 query1Ready,
  output logic [31:0]          query1Value,
  input  logic [ROB_WIDTH-1:0] query2Id,
  output logic                 query2Ready,
  output logic [31:0]          query2Value,
  output logic                 writeFlag,
  output logic [ROB_WIDTH-1:0] robId,
  output logic [4:0]           writeAddr,
  output logic [31:0]          writeValue,
  output logic                 clearOut,
  output logic [31:0]          redirectPc
);

  localparam int                 DEPTH   = 2 ** ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] c_depth = (ROB_WIDTH + 1)'(DEPTH);
  localparam logic [ROB_WIDTH:0] c_cnt1  = (ROB_WIDTH + 1)'(1);
  localparam logic [ROB_WIDTH-1:0] c_one = ROB_WIDTH'(1);

  logic [ROB_WIDTH-1:0] r_head;
  logic [ROB_WIDTH-1:0] r_tail;
  logic [ROB_WIDTH:0]   r_count;
  logic [DEPTH-1:0]     r_busy;
  logic [DEPTH-1:0]     r_ready;

  // Payload fields are only consumed while the matching busy/ready bit is set,
  // so they carry no reset.
  logic [DEPTH-1:0]     r_rdFlag;
  logic [DEPTH-1:0]     r_branch;
  logic [DEPTH-1:0]     r_mispredict;
  logic [4:0]           r_rd     [DEPTH];
  logic [31:0]          r_value  [DEPTH];
  logic [31:0]          r_target [DEPTH];

  logic w_issue;
  logic w_wb;
  logic w_commit;

  assign full     = (r_count == c_depth);
  assign issueId  = r_tail;
  assign w_issue  = readyIn && issueValid && !full && !clearOut;
  assign w_wb     = readyIn && cdbValid && r_busy[cdbRobId] && !clearOut;
  assign w_commit = readyIn && (r_count != '0) && r_ready[r_head] && !clearOut;

  // Operand lookup with same-cycle CDB bypass.
  always_comb begin
    query1Ready = r_busy[query1Id] && r_ready[query1Id];
    query1Value = r_value[query1Id];
    if (cdbValid && (cdbRobId == query1Id)) begin
      query1Ready = 1'b1;
      query1Value = cdbValue;
    end
    query2Ready = r_busy[query2Id] && r_ready[query2Id];
    query2Value = r_value[query2Id];
    if (cdbValid && (cdbRobId == query2Id)) begin
      query2Ready = 1'b1;
      query2Value = cdbValue;
    end
  end

  always_ff @(posedge clockIn) begin
    if (w_issue) begin
      r_rdFlag[r_tail]     <= issueRdFlag && (issueRd != 5'd0);
      r_rd[r_tail]         <= issueRd;
      r_branch[r_tail]     <= issueBranch;
      r_mispredict[r_tail] <= 1'b0;
    end
    if (w_wb) begin
      r_value[cdbRobId]      <= cdbValue;
      r_mispredict[cdbRobId] <= cdbMispredict;
      r_target[cdbRobId]     <= cdbTarget;
    end
  end

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_busy     <= '0;
      r_ready    <= '0;
      writeFlag  <= 1'b0;
      robId      <= '0;
      writeAddr  <= '0;
      writeValue <= '0;
      clearOut   <= 1'b0;
      redirectPc <= '0;
    end else if (readyIn) begin
      if (clearOut) begin
        r_head    <= '0;
        r_tail    <= '0;
        r_count   <= '0;
        r_busy    <= '0;
        r_ready   <= '0;
        clearOut  <= 1'b0;
        writeFlag <= 1'b0;
      end else begin
        if (w_issue) begin
          r_busy[r_tail]  <= 1'b1;
          r_ready[r_tail] <= 1'b0;
          r_tail          <= r_tail + c_one;
        end
        if (w_wb) begin
          r_ready[cdbRobId] <= 1'b1;
        end
        writeFlag <= 1'b0;
        // Placed after writeback so freeing the head wins over a late CDB hit.
        if (w_commit) begin
          writeFlag       <= r_rdFlag[r_head];
          robId           <= r_head;
          writeAddr       <= r_rd[r_head];
          writeValue      <= r_value[r_head];
          r_busy[r_head]  <= 1'b0;
          r_ready[r_head] <= 1'b0;
          r_head          <= r_head + c_one;
          if (r_branch[r_head] && r_mispredict[r_head]) begin
            clearOut   <= 1'b1;
            redirectPc <= r_target[r_head];
          end
        end
        case ({w_issue, w_commit})
          2'b10:   r_count <= r_count + c_cnt1;
          2'b01:   r_count <= r_count - c_cnt1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
